// File: rtl/stroke_draw_controller.sv
`default_nettype none
// ============================================================================
//  Module   : stroke_draw_controller
//  Purpose  : Arbitrates local/remote touch samples and expands each drawn
//             sample into a clipped BRUSHxBRUSH square of framebuffer writes.
//  Revision : 1.0  initial release
// ============================================================================
module stroke_draw_controller #(
    parameter int BRUSH = 3,
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        loc_valid_in,
    input  logic [8:0]  loc_x_in,
    input  logic [7:0]  loc_y_in,
    output logic        loc_ready_out,
    input  logic        rem_valid_in,
    input  logic [8:0]  rem_x_in,
    input  logic [7:0]  rem_y_in,
    input  logic [2:0]  rem_color_in,
    output logic        rem_ready_out,
    output logic        fb_valid_out,
    input  logic        fb_ready_in,
    output logic [16:0] fb_addr_out,
    output logic [2:0]  fb_color_out,
    output logic [2:0]  color_out,
    output logic        busy_out
);

    localparam int C_R = (BRUSH - 1) / 2;
    localparam logic signed [11:0] c_r_pos = 12'(C_R);
    localparam logic signed [11:0] c_r_neg = 12'(-C_R);
    localparam logic signed [11:0] c_h_res = 12'(H_RES);
    localparam logic signed [11:0] c_v_res = 12'(V_RES);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PAINT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio_rem;
    logic [8:0]         r_x;
    logic [7:0]         r_y;
    logic [2:0]         r_pix_color;
    logic [2:0]         r_pen;
    logic signed [11:0] r_dx;
    logic signed [11:0] r_dy;

    logic               w_gnt_loc;
    logic               w_gnt_rem;
    logic               w_loc_xfer;
    logic               w_rem_xfer;
    logic               w_pal_hit;
    logic [2:0]         w_pal_color;
    logic signed [11:0] w_px;
    logic signed [11:0] w_py;
    logic               w_inb;
    logic               w_last_dx;
    logic               w_last;
    logic               w_advance;
    logic [16:0]        w_addr;

    // Priority only matters when both requesters are valid at once.
    assign w_gnt_loc = loc_valid_in && (!rem_valid_in || !r_prio_rem);
    assign w_gnt_rem = rem_valid_in && (!loc_valid_in ||  r_prio_rem);

    assign loc_ready_out = (r_state == ST_IDLE) && !rst_in && w_gnt_loc;
    assign rem_ready_out = (r_state == ST_IDLE) && !rst_in && w_gnt_rem;
    assign w_loc_xfer    = loc_valid_in && loc_ready_out;
    assign w_rem_xfer    = rem_valid_in && rem_ready_out;

    assign w_pal_hit = (loc_x_in > 9'd20) && (loc_x_in < 9'd60) &&
                       (loc_y_in > 8'd20) && (loc_y_in < 8'd220);

    always_comb begin
        w_pal_color = 3'd4;
        if (loc_y_in < 8'd60)
            w_pal_color = 3'd0;
        else if (loc_y_in < 8'd100)
            w_pal_color = 3'd1;
        else if (loc_y_in < 8'd140)
            w_pal_color = 3'd2;
        else if (loc_y_in < 8'd180)
            w_pal_color = 3'd3;
    end

    // Signed pixel position so that brush pixels left/above the screen clip.
    assign w_px = $signed({3'b000, r_x}) + r_dx;
    assign w_py = $signed({4'b0000, r_y}) + r_dy;
    assign w_inb = (w_px >= 12'sd0) && (w_px < c_h_res) &&
                   (w_py >= 12'sd0) && (w_py < c_v_res);
    assign w_addr = 17'(w_py) * 17'(H_RES) + 17'(w_px);

    assign w_last_dx = (r_dx == c_r_pos);
    assign w_last    = w_last_dx && (r_dy == c_r_pos);
    assign w_advance = (r_state == ST_PAINT) && (!w_inb || fb_ready_in);

    assign busy_out     = (r_state == ST_PAINT);
    assign fb_valid_out = (r_state == ST_PAINT) && w_inb;
    assign fb_addr_out  = fb_valid_out ? w_addr : 17'd0;
    assign fb_color_out = fb_valid_out ? r_pix_color : 3'd0;
    assign color_out    = r_pen;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rem_xfer || (w_loc_xfer && !w_pal_hit))
                    w_state_nxt = ST_PAINT;
            end
            ST_PAINT: begin
                if (w_advance && w_last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_prio_rem  <= 1'b0;
            r_x         <= 9'd0;
            r_y         <= 8'd0;
            r_pix_color <= 3'd0;
            r_pen       <= 3'd0;
            r_dx        <= c_r_neg;
            r_dy        <= c_r_neg;
        end else begin
            if (w_loc_xfer) begin
                r_prio_rem <= 1'b1;
                r_x        <= loc_x_in;
                r_y        <= loc_y_in;
                if (w_pal_hit)
                    r_pen <= w_pal_color;
                else
                    r_pix_color <= r_pen;
            end else if (w_rem_xfer) begin
                r_prio_rem  <= 1'b0;
                r_x         <= rem_x_in;
                r_y         <= rem_y_in;
                r_pix_color <= rem_color_in;
            end

            if (w_loc_xfer || w_rem_xfer) begin
                r_dx <= c_r_neg;
                r_dy <= c_r_neg;
            end else if (w_advance) begin
                if (w_last) begin
                    r_dx <= c_r_neg;
                    r_dy <= c_r_neg;
                end else if (w_last_dx) begin
                    r_dx <= c_r_neg;
                    r_dy <= r_dy + 12'sd1;
                end else begin
                    r_dx <= r_dx + 12'sd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stroke_draw_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stroke_draw_controller
//  Purpose  : Directed self-checking bench for stroke_draw_controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stroke_draw_controller;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        loc_valid_in = 1'b0;
    logic [8:0]  loc_x_in = '0;
    logic [7:0]  loc_y_in = '0;
    logic        loc_ready_out;
    logic        rem_valid_in = 1'b0;
    logic [8:0]  rem_x_in = '0;
    logic [7:0]  rem_y_in = '0;
    logic [2:0]  rem_color_in = '0;
    logic        rem_ready_out;
    logic        fb_valid_out;
    logic        fb_ready_in = 1'b1;
    logic [16:0] fb_addr_out;
    logic [2:0]  fb_color_out;
    logic [2:0]  color_out;
    logic        busy_out;

    int total = 0;
    int bad   = 0;

    int got_addr[$];
    int got_color[$];
    int cyc_addr[$];
    int busy_cycles;
    bit timed_out;

    always #5 clk = ~clk;

    stroke_draw_controller #(.BRUSH(3), .H_RES(320), .V_RES(240)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .loc_valid_in  (loc_valid_in),
        .loc_x_in      (loc_x_in),
        .loc_y_in      (loc_y_in),
        .loc_ready_out (loc_ready_out),
        .rem_valid_in  (rem_valid_in),
        .rem_x_in      (rem_x_in),
        .rem_y_in      (rem_y_in),
        .rem_color_in  (rem_color_in),
        .rem_ready_out (rem_ready_out),
        .fb_valid_out  (fb_valid_out),
        .fb_ready_in   (fb_ready_in),
        .fb_addr_out   (fb_addr_out),
        .fb_color_out  (fb_color_out),
        .color_out     (color_out),
        .busy_out      (busy_out)
    );

    // One-cycle sample presented from a negedge; returns just after the accepting edge.
    task automatic issue(input bit rem, input logic [8:0] x, input logic [7:0] y,
                         input logic [2:0] c);
        @(negedge clk);
        if (rem) begin
            rem_valid_in = 1'b1; rem_x_in = x; rem_y_in = y; rem_color_in = c;
        end else begin
            loc_valid_in = 1'b1; loc_x_in = x; loc_y_in = y;
        end
        @(posedge clk);
        #1;
        loc_valid_in = 1'b0;
        rem_valid_in = 1'b0;
    endtask

    // Logs handshakes until PAINT ends; optionally stalls the write at index stall_at.
    task automatic collect(input int stall_at, input int stall_len);
        int  stalls = 0;
        bit  seen = 1'b0;
        got_addr.delete(); got_color.delete(); cyc_addr.delete();
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (seen && !busy_out) begin
                timed_out = 1'b0;
                break;
            end
            if (busy_out) begin
                seen = 1'b1;
                busy_cycles++;
            end
            if (fb_valid_out && got_addr.size() == stall_at && stalls < stall_len) begin
                fb_ready_in = 1'b0;
                stalls++;
            end else begin
                fb_ready_in = 1'b1;
            end
            if (fb_valid_out)
                cyc_addr.push_back(int'(fb_addr_out));
            if (fb_valid_out && fb_ready_in) begin
                got_addr.push_back(int'(fb_addr_out));
                got_color.push_back(int'(fb_color_out));
            end
        end
        fb_ready_in = 1'b1;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        loc_valid_in = 1'b1; loc_x_in = 9'd100; loc_y_in = 8'd100;
        rem_valid_in = 1'b1; rem_x_in = 9'd50;  rem_y_in = 8'd50;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({fb_valid_out, busy_out, loc_ready_out, rem_ready_out} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got v/b/lr/rr=%b want 0000",
                     {fb_valid_out, busy_out, loc_ready_out, rem_ready_out});
        end
        total++;
        if (fb_addr_out !== 17'd0 || fb_color_out !== 3'd0 || color_out !== 3'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%0d fbc=%0d pen=%0d want 0 0 0",
                     fb_addr_out, fb_color_out, color_out);
        end
        loc_valid_in = 1'b0;
        rem_valid_in = 1'b0;
        rst_in = 1'b0;
    endtask

    task automatic test_palette;
        @(negedge clk);
        loc_valid_in = 1'b1; loc_x_in = 9'd40; loc_y_in = 8'd110;
        #1;
        total++;
        if (loc_ready_out !== 1'b1 || rem_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL pal_ready: got lr=%b rr=%b want 1 0", loc_ready_out, rem_ready_out);
        end
        @(posedge clk);
        #1;
        loc_valid_in = 1'b0;
        total++;
        if (color_out !== 3'd2) begin
            bad++;
            $display("FAIL pal_color_2: got %0d want 2", color_out);
        end
        total++;
        if (fb_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL pal_nowrite: got v=%b busy=%b want 0 0", fb_valid_out, busy_out);
        end
        issue(1'b0, 9'd40, 8'd200, 3'd0);
        total++;
        if (color_out !== 3'd4) begin
            bad++;
            $display("FAIL pal_color_4: got %0d want 4", color_out);
        end
        @(negedge clk);
        total++;
        if (fb_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL pal_nowrite2: got v=%b busy=%b want 0 0", fb_valid_out, busy_out);
        end
    endtask

    task automatic test_draw;
        int exp_a[9];
        exp_a = '{15779, 15780, 15781, 16099, 16100, 16101, 16419, 16420, 16421};
        issue(1'b0, 9'd40, 8'd110, 3'd0);
        total++;
        if (color_out !== 3'd2) begin
            bad++;
            $display("FAIL draw_pen: got %0d want 2", color_out);
        end
        issue(1'b0, 9'd100, 8'd50, 3'd0);
        collect(-1, 0);
        total++;
        if (timed_out || got_addr.size() != 9) begin
            bad++;
            $display("FAIL draw_count: got %0d writes (timeout=%0d) want 9", got_addr.size(), timed_out);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < got_addr.size()) begin
                total++;
                if (got_addr[i] != exp_a[i] || got_color[i] != 2) begin
                    bad++;
                    $display("FAIL draw_px%0d: got addr=%0d color=%0d want %0d 2",
                             i, got_addr[i], got_color[i], exp_a[i]);
                end
            end
        end
        total++;
        if (busy_cycles != 9 || fb_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL draw_busy: got busy=%0d v_after=%b want 9 0", busy_cycles, fb_valid_out);
        end
    endtask

    task automatic test_back_pressure;
        int exp_a[9];
        exp_a = '{15779, 15780, 15781, 16099, 16100, 16101, 16419, 16420, 16421};
        issue(1'b0, 9'd100, 8'd50, 3'd0);
        collect(1, 5);
        total++;
        if (timed_out || got_addr.size() != 9 || cyc_addr.size() != 14) begin
            bad++;
            $display("FAIL bp_count: got writes=%0d valid_cycles=%0d want 9 14",
                     got_addr.size(), cyc_addr.size());
        end
        for (int i = 1; i <= 6; i++) begin
            if (i < cyc_addr.size()) begin
                total++;
                if (cyc_addr[i] != 15780) begin
                    bad++;
                    $display("FAIL bp_hold%0d: got addr=%0d want 15780", i, cyc_addr[i]);
                end
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (i < got_addr.size()) begin
                total++;
                if (got_addr[i] != exp_a[i]) begin
                    bad++;
                    $display("FAIL bp_px%0d: got %0d want %0d", i, got_addr[i], exp_a[i]);
                end
            end
        end
        total++;
        if (busy_cycles != 14) begin
            bad++;
            $display("FAIL bp_busy: got %0d want 14", busy_cycles);
        end
    endtask

    task automatic test_clip;
        int exp_lo[4];
        int exp_hi[4];
        exp_lo = '{0, 1, 320, 321};
        exp_hi = '{76478, 76479, 76798, 76799};
        issue(1'b1, 9'd0, 8'd0, 3'd3);
        collect(-1, 0);
        total++;
        if (timed_out || got_addr.size() != 4 || busy_cycles != 9) begin
            bad++;
            $display("FAIL clip_lo_count: got writes=%0d busy=%0d want 4 9", got_addr.size(), busy_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got_addr.size()) begin
                total++;
                if (got_addr[i] != exp_lo[i] || got_color[i] != 3) begin
                    bad++;
                    $display("FAIL clip_lo%0d: got addr=%0d color=%0d want %0d 3",
                             i, got_addr[i], got_color[i], exp_lo[i]);
                end
            end
        end
        issue(1'b1, 9'd319, 8'd239, 3'd3);
        collect(-1, 0);
        total++;
        if (timed_out || got_addr.size() != 4 || busy_cycles != 9) begin
            bad++;
            $display("FAIL clip_hi_count: got writes=%0d busy=%0d want 4 9", got_addr.size(), busy_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < got_addr.size()) begin
                total++;
                if (got_addr[i] != exp_hi[i] || got_color[i] != 3) begin
                    bad++;
                    $display("FAIL clip_hi%0d: got addr=%0d color=%0d want %0d 3",
                             i, got_addr[i], got_color[i], exp_hi[i]);
                end
            end
        end
    endtask

    task automatic test_arbitration;
        int grants[$];
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        fb_ready_in = 1'b1;
        loc_valid_in = 1'b1; loc_x_in = 9'd100; loc_y_in = 8'd100;
        rem_valid_in = 1'b1; rem_x_in = 9'd200; rem_y_in = 8'd150; rem_color_in = 3'd1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (grants.size() == 4) begin
                loc_valid_in = 1'b0;
                rem_valid_in = 1'b0;
                break;
            end
            total++;
            if ((loc_ready_out && rem_ready_out) || (busy_out && (loc_ready_out || rem_ready_out))) begin
                bad++;
                $display("FAIL arb_ready: got lr=%b rr=%b busy=%b", loc_ready_out, rem_ready_out, busy_out);
            end
            if (loc_ready_out) grants.push_back(0);
            else if (rem_ready_out) grants.push_back(1);
            @(negedge clk);
        end
        loc_valid_in = 1'b0;
        rem_valid_in = 1'b0;
        total++;
        if (grants.size() != 4) begin
            bad++;
            $display("FAIL arb_count: got %0d grants want 4", grants.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) begin
                total++;
                if (grants[i] != exp_g[i]) begin
                    bad++;
                    $display("FAIL arb_order%0d: got %0d want %0d (0=local)", i, grants[i], exp_g[i]);
                end
            end
        end
        collect(-1, 0);
    endtask

    task automatic test_reset_mid;
        int writes = 0;
        bit hit = 1'b0;
        issue(1'b0, 9'd40, 8'd110, 3'd0);
        issue(1'b0, 9'd100, 8'd50, 3'd0);
        fb_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fb_valid_out) writes++;
            if (writes == 4) begin
                hit = 1'b1;
                rst_in = 1'b1;
                loc_valid_in = 1'b1; loc_x_in = 9'd150; loc_y_in = 8'd150;
                rem_valid_in = 1'b1; rem_x_in = 9'd250; rem_y_in = 8'd200;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_mid_reach: got %0d writes want 4", writes);
        end
        @(negedge clk);
        total++;
        if (fb_valid_out !== 1'b0 || busy_out !== 1'b0 || color_out !== 3'd0) begin
            bad++;
            $display("FAIL rst_mid_state: got v=%b busy=%b pen=%0d want 0 0 0",
                     fb_valid_out, busy_out, color_out);
        end
        rst_in = 1'b0;
        #1;
        total++;
        if (loc_ready_out !== 1'b1 || rem_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_prio: got lr=%b rr=%b want 1 0", loc_ready_out, rem_ready_out);
        end
        loc_valid_in = 1'b0;
        rem_valid_in = 1'b0;
        @(negedge clk);
        total++;
        if (busy_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle: got busy=%b want 0", busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_palette();
        test_draw();
        test_back_pressure();
        test_clip();
        test_arbitration();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
